// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: mode encoding and mode classifiers.
// Combinational helpers only; no state.
package usr_pkg;

  typedef enum logic [2:0] {
    USR_HOLD  = 3'd0,
    USR_LOAD  = 3'd1,
    USR_SHL   = 3'd2,
    USR_SHR   = 3'd3,
    USR_ROL   = 3'd4,
    USR_ROR   = 3'd5,
    USR_CLEAR = 3'd6,
    USR_RSVD  = 3'd7
  } usr_mode_e;

  function automatic logic is_shift(input usr_mode_e m);
    return (m == USR_SHL) || (m == USR_SHR) || (m == USR_ROL) || (m == USR_ROR);
  endfunction

  // Modes that restart the shift count.
  function automatic logic is_restart(input usr_mode_e m);
    return (m == USR_LOAD) || (m == USR_CLEAR);
  endfunction

endpackage

// File: rtl/usr_sat_counter.sv
// Saturating up-counter, 1-cycle update; clr beats inc, holds at MAX.
// No backpressure: the caller gates inc/clr with its own enable.
module usr_sat_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + W'(1);
    end
  end

  // Decoded from the registered count so it rises on the same edge cnt hits MAX.
  assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register (load/shift/rotate/clear), 1-cycle latency, with shift counter.
// No backpressure; en=0 freezes the word and the count.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  usr_mode_e        mode,
  input  logic [WIDTH-1:0] d_par,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             cnt_done
);

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] shr_v;
  logic [WIDTH-1:0] rol_v;
  logic [WIDTH-1:0] ror_v;

  // A 1-bit word has no neighbours: shifts take the serial input, rotates are identity.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shl_v = ser_in_lsb;
      assign shr_v = ser_in_msb;
      assign rol_v = q;
      assign ror_v = q;
    end else begin : g_wn
      assign shl_v = {q[WIDTH-2:0], ser_in_lsb};
      assign shr_v = {ser_in_msb, q[WIDTH-1:1]};
      assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};
      assign ror_v = {q[0], q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    q_nxt = q;
    if (en) begin
      case (mode)
        USR_LOAD:  q_nxt = d_par;
        USR_SHL:   q_nxt = shl_v;
        USR_SHR:   q_nxt = shr_v;
        USR_ROL:   q_nxt = rol_v;
        USR_ROR:   q_nxt = ror_v;
        USR_CLEAR: q_nxt = RESET_VALUE;
        default:   q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= q_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && en && (mode == USR_RSVD)) begin
      $warning("universal_shift_reg: reserved mode 7 selected, holding");
    end
  end

  usr_sat_counter #(
    .MAX (WIDTH),
    .W   (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (en && is_restart(mode)),
    .inc    (en && is_shift(mode)),
    .cnt    (shift_cnt),
    .at_max (cnt_done)
  );

  assign ser_out_msb = q[WIDTH-1];
  assign ser_out_lsb = q[0];

endmodule
